// File: rtl/seq_counter_7seg.sv
// Multi-digit BCD sequence counter with a time-base prescaler and a
// multiplexed 7-segment scan driver.
module seq_counter_7seg #(
   parameter int unsigned NUM_DIGITS     = 2,
   parameter int unsigned TICK_DIV       = 20000000,
   parameter int unsigned SCAN_DIV       = 1000,
   parameter int unsigned MAX_COUNT      = 99,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          BLANK_LZ       = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [1:0]              mode,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_val,
   output logic [4*NUM_DIGITS-1:0] count,
   output logic                    step,
   output logic                    wrap,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_sel
);
   localparam int unsigned CW     = 4 * NUM_DIGITS;
   localparam int unsigned DIV_W  = $clog2(TICK_DIV);
   localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   function automatic logic [CW-1:0] to_bcd(input int unsigned v);
      logic [CW-1:0] r;
      int unsigned   x;
      r = '0;
      x = v;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          b;
      r = v;
      b = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
            else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Segment pattern {a..g} with 1 = lit; non-decimal codes stay dark.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1111110;
         4'd1:    return 7'b0110000;
         4'd2:    return 7'b1101101;
         4'd3:    return 7'b1111001;
         4'd4:    return 7'b0110011;
         4'd5:    return 7'b1011011;
         4'd6:    return 7'b1011111;
         4'd7:    return 7'b1110000;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   localparam logic [CW-1:0] MAX_BCD   = to_bcd(MAX_COUNT);
   localparam logic [CW-1:0] MAXM1_BCD = to_bcd(MAX_COUNT - 1);
   localparam logic [CW-1:0] ONE_BCD   = to_bcd(1);
   localparam logic [6:0]    SEG_RST   = SEG_ACTIVE_LOW ? ~7'b1111110 : 7'b1111110;

   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   dir_t              dir, dir_nx;
   logic [DIV_W-1:0]  div_cnt, div_nx;
   logic [CW-1:0]     count_nx;
   logic              step_nx, wrap_nx, expire, load_ok;
   logic [SCAN_W-1:0] scan_cnt;
   logic [IDX_W-1:0]  idx;
   logic              scan_hit, zero_above, cur_blank;
   logic [3:0]        cur_digit;
   logic [6:0]        lit, seg_nx;
   logic [NUM_DIGITS-1:0] sel_nx;

   always_comb begin
      div_nx   = div_cnt;
      count_nx = count;
      dir_nx   = dir;
      step_nx  = 1'b0;
      wrap_nx  = 1'b0;
      expire   = en && (div_cnt == DIV_W'(TICK_DIV - 1));
      // Valid BCD compares correctly as a plain unsigned vector.
      load_ok  = (load_val <= MAX_BCD);
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
         if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
      if (mode != 2'b10) dir_nx = DIR_UP;
      if (load) begin
         div_nx   = '0;
         dir_nx   = DIR_UP;
         count_nx = load_ok ? load_val : '0;
      end else if (expire) begin
         div_nx  = '0;
         step_nx = 1'b1;
         case (mode)
            2'b00: begin
               if (count == MAX_BCD) begin
                  count_nx = '0;
                  wrap_nx  = 1'b1;
               end else count_nx = bcd_inc(count);
            end
            2'b01: begin
               if (count == '0) begin
                  count_nx = MAX_BCD;
                  wrap_nx  = 1'b1;
               end else count_nx = bcd_dec(count);
            end
            2'b10: begin
               if (dir == DIR_UP) begin
                  if (count == MAX_BCD) begin
                     count_nx = MAXM1_BCD;
                     dir_nx   = DIR_DOWN;
                     wrap_nx  = 1'b1;
                  end else count_nx = bcd_inc(count);
               end else begin
                  if (count == '0) begin
                     count_nx = ONE_BCD;
                     dir_nx   = DIR_UP;
                     wrap_nx  = 1'b1;
                  end else count_nx = bcd_dec(count);
               end
            end
            default: ;
         endcase
      end else if (en) begin
         div_nx = div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         div_cnt <= '0;
         step    <= 1'b0;
         wrap    <= 1'b0;
         dir     <= DIR_UP;
      end else begin
         count   <= count_nx;
         div_cnt <= div_nx;
         step    <= step_nx;
         wrap    <= wrap_nx;
         dir     <= dir_nx;
      end
   end

   // Scan from the top digit down so zero_above covers digit k and all above it.
   always_comb begin
      scan_hit   = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
      cur_digit  = '0;
      cur_blank  = 1'b0;
      zero_above = 1'b1;
      sel_nx     = '0;
      for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
         zero_above = zero_above && (count[4*(k-1) +: 4] == 4'd0);
         if (idx == IDX_W'(k - 1)) begin
            cur_digit     = count[4*(k-1) +: 4];
            cur_blank     = BLANK_LZ && (k > 1) && zero_above;
            sel_nx[k-1]   = 1'b1;
         end
      end
      lit    = cur_blank ? 7'b0000000 : seg7(cur_digit);
      seg_nx = SEG_ACTIVE_LOW ? ~lit : lit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= '0;
         seg      <= SEG_RST;
         dig_sel  <= NUM_DIGITS'(1);
      end else begin
         if (scan_hit) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         seg     <= seg_nx;
         dig_sel <= sel_nx;
      end
   end
endmodule

// File: tb/tb_seq_counter_7seg.sv
// Scoreboard bench for seq_counter_7seg: expected steps are queued by the
// stimulus process and popped by a monitor whenever step pulses.
module tb_seq_counter_7seg;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] load_val = 8'h00;
   logic [7:0] count;
   logic       step, wrap;
   logic [6:0] seg;
   logic [1:0] dig_sel;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int         cyc;
      logic [7:0] count;
      logic       wrap;
   } exp_t;
   exp_t sbq[$];

   seq_counter_7seg #(
      .NUM_DIGITS(2),
      .TICK_DIV(4),
      .SCAN_DIV(2),
      .MAX_COUNT(12),
      .SEG_ACTIVE_LOW(1'b1),
      .BLANK_LZ(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .mode(mode),
      .load(load),
      .load_val(load_val),
      .count(count),
      .step(step),
      .wrap(wrap),
      .seg(seg),
      .dig_sel(dig_sel)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] bcd8(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_step(input int c, input logic [7:0] cnt, input logic w);
      exp_t e;
      e.cyc   = c;
      e.count = cnt;
      e.wrap  = w;
      sbq.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (wrap && !step) begin
            checks++;
            failures++;
            $display("FAIL wrap_without_step: wrap=1 step=0 required wrap=0 (cycle %0d)", cyc);
         end
         if (step) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_step: step with count %0h, required no step (cycle %0d)", count, cyc);
            end else begin
               e = sbq.pop_front();
               check("step_cycle", cyc, e.cyc);
               check("step_count", count, e.count);
               check("step_wrap", wrap, e.wrap);
            end
         end
      end
   end

   initial begin
      int c0, c1, ld, m, s;

      tick(3);
      check("rst_count", count, 8'h00);
      check("rst_seg", seg, 7'b0000001);
      check("rst_dig_sel", dig_sel, 2'b01);
      check("rst_step", step, 1'b0);
      check("rst_wrap", wrap, 1'b0);

      // Run up to 07, then reset asynchronously mid-cycle.
      rst = 1'b0; en = 1'b1; mode = 2'b00;
      c0 = cyc;
      for (int k = 1; k <= 7; k++) expect_step(c0 + 4*k, bcd8(k), 1'b0);
      tick(30);
      check("pre_rst_count", count, 8'h07);
      rst = 1'b1;
      #2;
      check("async_rst_count", count, 8'h00);
      check("async_rst_seg", seg, 7'b0000001);
      check("async_rst_dig_sel", dig_sel, 2'b01);
      tick(2);

      // Up with a 3-cycle en gap after the sixth step.
      rst = 1'b0;
      c1 = cyc;
      for (int k = 1; k <= 6; k++) expect_step(c1 + 4*k, bcd8(k), 1'b0);
      for (int k = 7; k <= 13; k++) expect_step(c1 + 31 + 4*(k-7), bcd8(k % 13), k == 13);
      tick(25);
      en = 1'b0;
      tick(3);
      en = 1'b1;
      tick(27);
      check("up_wrapped_count", count, 8'h00);

      // Down from 00.
      mode = 2'b01;
      expect_step(c1 + 59, 8'h12, 1'b1);
      expect_step(c1 + 63, 8'h11, 1'b0);
      tick(8);

      // Ping-pong from a loaded 11.
      load = 1'b1; load_val = 8'h11; mode = 2'b10;
      tick(1);
      load = 1'b0;
      ld = cyc;
      check("pp_load_count", count, 8'h11);
      check("pp_load_no_step", step, 1'b0);
      expect_step(ld + 4, 8'h12, 1'b0);
      expect_step(ld + 8, 8'h11, 1'b1);
      for (int j = 10; j >= 0; j--) expect_step(ld + 8 + 4*(11-j), bcd8(j), 1'b0);
      expect_step(ld + 56, 8'h01, 1'b1);
      tick(56);

      // Loads: invalid digit, valid, over maximum, then one on a step cycle.
      mode = 2'b00;
      load = 1'b1; load_val = 8'h1A;
      tick(1);
      check("load_bad_digit", count, 8'h00);
      load_val = 8'h07;
      tick(1);
      check("load_valid", count, 8'h07);
      load_val = 8'h13;
      tick(1);
      check("load_over_max", count, 8'h00);
      load = 1'b0;
      tick(3);
      load = 1'b1; load_val = 8'h05;
      tick(1);
      load = 1'b0;
      check("load_on_step_count", count, 8'h05);
      check("load_on_step_no_step", step, 1'b0);
      check("load_on_step_no_wrap", wrap, 1'b0);
      expect_step(ld + 67, 8'h06, 1'b0);
      tick(4);

      // Freeze at 05 and check the scan; selection phase counts from reset release c1.
      en = 1'b0; load = 1'b1; load_val = 8'h05;
      tick(1);
      load = 1'b0;
      tick(2);
      for (int i = 0; i < 8; i++) begin
         m = cyc - c1;
         s = ((m - 1) / 2) % 2;
         check("scan05_dig_sel", dig_sel, (s == 1) ? 2'b10 : 2'b01);
         check("scan05_seg", seg, (s == 1) ? 7'b1111111 : 7'b0100100);
         tick(1);
      end

      load = 1'b1; load_val = 8'h10;
      tick(1);
      load = 1'b0;
      tick(2);
      for (int i = 0; i < 4; i++) begin
         m = cyc - c1;
         s = ((m - 1) / 2) % 2;
         check("scan10_dig_sel", dig_sel, (s == 1) ? 2'b10 : 2'b01);
         check("scan10_seg", seg, (s == 1) ? 7'b1001111 : 7'b0000001);
         tick(1);
      end

      check("scoreboard_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seq_counter_7seg.md
# seq_counter_7seg

Parametrised multi-digit BCD sequence counter with a built-in time-base prescaler and a multiplexed 7-segment driver, for board-level demo designs. It generalises our single-digit, fixed-sequence display counter: configurable digit count, modulus, step rate and display polarity, plus runtime up/down/ping-pong/hold modes, synchronous load, and leading-zero blanking. It sits between the on-chip system clock and the board's segment and digit-enable pins.

## Interface
- NUM_DIGITS, 2, BCD digits (1..4)
- TICK_DIV, 20000000, clk cycles per count step (≥2)
- SCAN_DIV, 1000, clk cycles per display-digit advance (≥1)
- MAX_COUNT, 99, last value of the sequence, decimal (1 .. 10^NUM_DIGITS−1)
- SEG_ACTIVE_LOW, 1, 1: segment lit when its bit is 0
- BLANK_LZ, 1, 1: blank higher-order zero digits
- clk  in  1  system clock; the block uses one clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  prescaler run enable
- mode  in  2  00 up, 01 down, 10 ping-pong, 11 hold
- load  in  1  synchronous load strobe
- load_val  in  4*NUM_DIGITS  BCD load value, digit 0 in bits [3:0]
- count  out  4*NUM_DIGITS  current BCD count
- step  out  1  one-cycle pulse per prescaler expiry
- wrap  out  1  one-cycle pulse on sequence wrap or reversal
- seg  out  7  {a,b,c,d,e,f,g}, a = bit 6
- dig_sel  out  NUM_DIGITS  one-hot digit enable, active-high

## Operation
- Prescaler div_cnt runs 0..TICK_DIV−1 while en=1 and holds while en=0. On the edge where div_cnt==TICK_DIV−1 and en=1: div_cnt←0, count updates, and step←1 for one cycle.
- Update rules on a step:
  - Up: count==MAX_COUNT → 0 with wrap; otherwise +1 with decimal carry.
  - Down: count==0 → MAX_COUNT with wrap; otherwise −1 with decimal borrow.
  - Ping-pong: uses an internal dir flag. dir=up and count==MAX_COUNT → count←MAX_COUNT−1, dir←down, wrap. dir=down and count==0 → count←1, dir←up, wrap. Otherwise count steps in direction dir.
  - Hold: count unchanged, step still pulses, wrap stays 0.
- dir resets to up on rst, on load, and on every cycle where mode≠10.
- Load has priority over a coincident step. On load: count←load_val if every digit ≤9 and the value ≤MAX_COUNT, otherwise count←0. div_cnt←0. No step or wrap pulse on the load cycle.
- Display scan:
  - The scan counter runs 0..SCAN_DIV−1 regardless of en.
  - On scan counter expiry, digit index idx advances cyclically 0..NUM_DIGITS−1.
  - dig_sel = one-hot(idx); seg = decode(count digit idx).
- Decode uses standard patterns for 0–9: 0 lights a–f; 1 lights b,c; … 8 lights all; 9 lights a,b,c,d,f,g.
- Blanking: with BLANK_LZ=1, digit k>0 is blank (no segments lit) when digit k and all digits above it are 0. Digit 0 is never blanked.
- Polarity: lit = !SEG_ACTIVE_LOW.
- With NUM_DIGITS=1, dig_sel is constant 1.

## Timing
- Reset values (applied asynchronously):
  - count=0, div_cnt=0, step=0, wrap=0, dir=up, idx=0.
  - dig_sel = 1 in bit 0.
  - seg shows "0": 7'b0000001 when active-low, 7'b1111110 when active-high.
- Releasing rst mid-count restarts the full TICK_DIV period.
- count, step and wrap are registered and change on the same edge. step/wrap are high during the first cycle the new count is visible.
- Step period is exactly TICK_DIV cycles with en held high. Deasserting en pauses div_cnt without loss of phase.
- seg and dig_sel are registered: one cycle of latency from an idx or count change. seg and dig_sel always change together.
- A mode change takes effect at the next step.
- A load during a step cycle suppresses that step.

## Test plan
Parameters for all tests: NUM_DIGITS=2, TICK_DIV=4, SCAN_DIV=2, MAX_COUNT=12, active-low, BLANK_LZ=1.
- Reset: assert rst mid-run at count 07 → count 00, seg 7'b0000001, dig_sel 2'b01 before the next clk edge. Release → first step exactly 4 cycles later.
- Up: mode 00, en=1 for 13 steps → count 01..12 then 00, steps 4 cycles apart, wrap high only on the 12→00 step. Drop en for 3 cycles mid-run → the next step is delayed by exactly 3 cycles.
- Down: mode 01 from 00 → 12 with wrap, then 11 without wrap.
- Ping-pong: load 11, mode 10 → 12, 11 (wrap), 10 … 00, 01 (wrap).
- Load: load 0x1A → 00; load 0x13 → 00; load 0x05 on a step cycle → count 05 with no step pulse, and the next step 4 cycles later gives 06.
- Scan: count 05 → dig_sel alternates 01/10 every 2 cycles. Digit 0 seg = 7'b0100100; digit 1 seg = 7'b1111111 (blank). At count 10, digit 1 seg = 7'b1001111.
